miriscv_data_arbiter: RTL and testbench
=======================================

Name: miriscv_data_arbiter

Overview:
- Shares the single RAM data port between two requesters: m0 is the core load/store unit and m1 is a secondary master (DMA or debug loader).
- Arbitrates between them round-robin.
- Decodes addresses against RAM_SIZE and rejects out-of-range accesses with an error response.
- Tracks the one-cycle RAM read latency so each response returns to the requester that issued it.
- Sits between the processor or secondary master and the RAM data port, inside the top level.

Parameters:
- RAM_SIZE, 256: RAM size in bytes. An address is valid iff addr < RAM_SIZE.
- ADDR_W, 32: address width.
- DATA_W, 32: data width. Byte-enable width is DATA_W/8.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous, active-high reset.
- m0_req_i / m1_req_i  in  1  request. Held with its attributes until gnt.
- m0_we_i / m1_we_i  in  1  1 = write, 0 = read.
- m0_be_i / m1_be_i  in  4  byte enables.
- m0_addr_i / m1_addr_i  in  ADDR_W  byte address.
- m0_wdata_i / m1_wdata_i  in  DATA_W  write data.
- m0_gnt_o / m1_gnt_o  out  1  request accepted this cycle (combinational).
- m0_rvalid_o / m1_rvalid_o  out  1  response valid. Asserted exactly one cycle after gnt.
- m0_rdata_o / m1_rdata_o  out  DATA_W  read data, valid with rvalid. Zero for writes and errors.
- m0_err_o / m1_err_o  out  1  error flag, valid with rvalid.
- ram_req_o  out  1  RAM data request.
- ram_we_o  out  1  RAM write enable.
- ram_be_o  out  4  RAM byte enables.
- ram_addr_o  out  ADDR_W  RAM address.
- ram_wdata_o  out  DATA_W  RAM write data.
- ram_rdata_i  in  DATA_W  RAM read data, valid the cycle after ram_req_o with we = 0.

Behaviour:
- Reset (synchronous, rst_i = 1):
  - Registered state cleared: prio_q = M0, resp_valid_q = 0, resp_owner_q = M0, resp_err_q = 0, resp_we_q = 0.
  - All outputs are 0 during and after reset until a request arrives.
- Arbitration:
  - Combinational, each cycle.
  - Single requester: it wins.
  - Both requesting: the master indicated by prio_q wins.
  - Exactly one gnt per cycle, only to the winner. No requester means no gnt.
- Priority update:
  - On any grant, prio_q takes the loser of that grant, i.e. the non-winning master.
  - With no grant, prio_q holds.
  - Guarantees alternation under continuous contention. Worst-case wait is 1 cycle.
- Address decode:
  - Valid iff addr < RAM_SIZE, full ADDR_W unsigned compare.
  - Invalid or be == 0: gnt is still asserted and ram_req_o stays 0. The next cycle gives rvalid = 1, err = 1, rdata = 0.
- RAM drive:
  - ram_req_o = gnt_any & valid.
  - ram_we/be/addr/wdata are muxed from the winner.
  - With no winner they are driven 0.
- Response tracking: on gnt, register resp_valid_q = 1, resp_owner_q = winner, resp_err_q = !valid, resp_we_q = we. Otherwise resp_valid_q = 0.
- Response output:
  - Only the owner's rvalid is asserted.
  - rdata = ram_rdata_i if read and no error, else 0.
  - err = resp_err_q.
  - The non-owner's rvalid, rdata and err are 0.
- Pipelining:
  - Back-to-back grants are allowed every cycle, including alternating masters.
  - The response for cycle-N grant is presented in N+1, concurrently with the cycle-N+1 grant.
- Writes: the RAM commits on the edge ending the grant cycle. The N+1 rvalid is a write ack with rdata 0.
- Reset mid-operation: a pending response is dropped with no rvalid, and the RAM request in the reset cycle is suppressed (ram_req_o = 0 while rst_i).
- Requester dropping req without gnt: permitted, no effect.

Decomposition:
- Package miriscv_arb_pkg:
  - typedef enum logic {M0, M1} master_e.
  - typedef struct packed mem_req_t {we, be, addr, wdata}.
  - Constant NUM_MASTERS = 2.
- Sub-module miriscv_rr_arbiter2: 2-input round-robin grant logic plus prio_q register.
- Decode, mux and response tracking stay in the top of the block.

Test Plan:
- Reset, then idle: all outputs 0 and no ram_req_o. After the first m1-only request, m1_gnt = 1 in the same cycle.
- m0 write 0xDEADBEEF to 0x10 with be = 0xF, then m0 read of 0x10:
  - gnt in cycles N and N+1.
  - rvalid in N+1 (rdata 0) and N+2 (rdata 0xDEADBEEF).
- Both masters continuously request reads for 6 cycles from reset: grants go m0, m1, m0, m1, m0, m1, and every rvalid goes to the correct owner one cycle later.
- m1 read of addr 0x100 with RAM_SIZE = 256: m1_gnt = 1, ram_req_o = 0, next cycle m1_rvalid = 1, m1_err = 1, m1_rdata = 0.
- Read of 0x20 where RAM holds 0x12345678, rvalid due the next cycle: rst_i is asserted in the cycle rvalid is due, so no rvalid appears and prio_q = M0 afterwards.
- m0 write with be = 0x0: gnt is asserted, no RAM write occurs, and next-cycle err = 1.

Source files
------------

// File: rtl/miriscv_data_arbiter_pkg.sv
// Shared types for the RAM data-port arbiter: master identifiers and the
// request bundle that is muxed from the winning master onto the RAM port.
package miriscv_arb_pkg;

    localparam int NUM_MASTERS = 2;
    localparam int ARB_ADDR_W  = 32;
    localparam int ARB_DATA_W  = 32;
    localparam int ARB_BE_W    = ARB_DATA_W / 8;

    typedef enum logic {
        M0 = 1'b0,
        M1 = 1'b1
    } master_e;

    typedef struct packed {
        logic                  we;
        logic [ARB_BE_W-1:0]   be;
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_DATA_W-1:0] wdata;
    } mem_req_t;

    function automatic master_e other_master(master_e m);
        return (m == M0) ? M1 : M0;
    endfunction

endpackage

// File: rtl/miriscv_data_arbiter_if.sv
// Requester-side bus (req/gnt/rvalid handshake) and the RAM data-port bus.
interface miriscv_data_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  req;
    logic                  we;
    logic [DATA_W/8-1:0]   be;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic                  gnt;
    logic                  rvalid;
    logic [DATA_W-1:0]     rdata;
    logic                  err;

    modport master (output req, we, be, addr, wdata, input gnt, rvalid, rdata, err);
    modport slave  (input req, we, be, addr, wdata, output gnt, rvalid, rdata, err);
endinterface

interface miriscv_ram_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  req;
    logic                  we;
    logic [DATA_W/8-1:0]   be;
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W-1:0]     rdata;

    modport master (output req, we, be, addr, wdata, input rdata);
    modport slave  (input req, we, be, addr, wdata, output rdata);
endinterface

// File: rtl/miriscv_rr_arbiter2.sv
// Two-input round-robin grant logic; prio_q names the master that wins the
// next contended cycle and flips to the loser after every grant.
module miriscv_rr_arbiter2
    import miriscv_arb_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_MASTERS-1:0] req,
    output logic [NUM_MASTERS-1:0] gnt,
    output master_e                winner,
    output logic                   gnt_any
);

    master_e prio_q;

    always_comb begin
        gnt     = '0;
        winner  = M0;
        gnt_any = |req;
        if (req == 2'b11) begin
            winner = prio_q;
        end else if (req[1]) begin
            winner = M1;
        end
        if (gnt_any) begin
            gnt[winner] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prio_q <= M0;
        end else if (gnt_any) begin
            prio_q <= other_master(winner);
        end
    end

endmodule

// File: rtl/miriscv_data_arbiter.sv
// Shares the RAM data port between the LSU (m0) and a secondary master (m1):
// round-robin grant, address range check, and one-cycle response routing.
module miriscv_data_arbiter
    import miriscv_arb_pkg::*;
#(
    parameter int RAM_SIZE = 256,
    parameter int ADDR_W   = ARB_ADDR_W,
    parameter int DATA_W   = ARB_DATA_W
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    miriscv_data_arbiter_if.slave   m0,
    miriscv_data_arbiter_if.slave   m1,
    miriscv_ram_if.master           ram
);

    logic [NUM_MASTERS-1:0] req;
    logic [NUM_MASTERS-1:0] gnt;
    master_e                winner;
    logic                   gnt_any;

    // Masking requests during reset keeps gnt and the whole RAM port at zero.
    assign req = {m1.req, m0.req} & {NUM_MASTERS{~rst_i}};

    miriscv_rr_arbiter2 u_rr_arbiter2 (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req     (req),
        .gnt     (gnt),
        .winner  (winner),
        .gnt_any (gnt_any)
    );

    mem_req_t m0_req;
    mem_req_t m1_req;
    mem_req_t win_req;
    logic     addr_ok;

    assign m0_req = '{we: m0.we, be: m0.be, addr: m0.addr, wdata: m0.wdata};
    assign m1_req = '{we: m1.we, be: m1.be, addr: m1.addr, wdata: m1.wdata};

    always_comb begin
        win_req = '0;
        if (gnt_any) begin
            win_req = (winner == M1) ? m1_req : m0_req;
        end
    end

    // Zero byte enables are treated like an out-of-range access: acked with err.
    assign addr_ok = (win_req.addr < ADDR_W'(RAM_SIZE)) && (win_req.be != '0);

    assign m0.gnt    = gnt[0];
    assign m1.gnt    = gnt[1];
    assign ram.req   = gnt_any & addr_ok;
    assign ram.we    = win_req.we;
    assign ram.be    = win_req.be;
    assign ram.addr  = win_req.addr;
    assign ram.wdata = win_req.wdata;

    logic    resp_valid_q;
    master_e resp_owner_q;
    logic    resp_err_q;
    logic    resp_we_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            resp_valid_q <= 1'b0;
            resp_owner_q <= M0;
            resp_err_q   <= 1'b0;
            resp_we_q    <= 1'b0;
        end else begin
            resp_valid_q <= gnt_any;
            if (gnt_any) begin
                resp_owner_q <= winner;
                resp_err_q   <= ~addr_ok;
                resp_we_q    <= win_req.we;
            end
        end
    end

    logic              resp_fire;
    logic              rsp0;
    logic              rsp1;
    logic [DATA_W-1:0] resp_rdata;

    // A response pending across a reset edge is dropped rather than delivered.
    assign resp_fire  = resp_valid_q & ~rst_i;
    assign rsp0       = resp_fire & (resp_owner_q == M0);
    assign rsp1       = resp_fire & (resp_owner_q == M1);
    assign resp_rdata = (resp_we_q | resp_err_q) ? '0 : ram.rdata;

    assign m0.rvalid = rsp0;
    assign m0.rdata  = rsp0 ? resp_rdata : '0;
    assign m0.err    = rsp0 & resp_err_q;
    assign m1.rvalid = rsp1;
    assign m1.rdata  = rsp1 ? resp_rdata : '0;
    assign m1.err    = rsp1 & resp_err_q;

endmodule

// File: tb/tb_miriscv_data_arbiter.sv
// Bench for miriscv_data_arbiter: behavioural RAM, per-cycle reference model
// and directed scenarios with literal expectations.
module tb_miriscv_data_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    miriscv_data_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m0_if ();
    miriscv_data_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m1_if ();
    miriscv_ram_if          #(.ADDR_W(32), .DATA_W(32)) ram_if ();

    miriscv_data_arbiter #(.RAM_SIZE(256), .ADDR_W(32), .DATA_W(32)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .m0    (m0_if),
        .m1    (m1_if),
        .ram   (ram_if)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural RAM on the arbiter's RAM port; idle/write cycles return junk.
    logic [31:0] ram_mem [64];
    logic [31:0] gold    [64];
    initial begin
        for (int i = 0; i < 64; i++) begin
            ram_mem[i] = '0;
            gold[i]    = '0;
        end
        ram_if.rdata = 32'hA5A5_5A5A;
    end

    always @(posedge clk) begin
        if (ram_if.req && !ram_if.we) begin
            ram_if.rdata <= ram_mem[ram_if.addr[7:2]];
        end else begin
            ram_if.rdata <= $urandom;
            if (ram_if.req) begin
                for (int b = 0; b < 4; b++)
                    if (ram_if.be[b]) ram_mem[ram_if.addr[7:2]][8*b +: 8] <= ram_if.wdata[8*b +: 8];
            end
        end
    end

    // Reference model: who wins, what the RAM sees, and what comes back next cycle.
    logic        m_prio1 = 1'b0;
    logic        pend_v = 1'b0, pend_own1 = 1'b0, pend_err = 1'b0;
    logic [31:0] pend_rd = '0;
    logic        any, w1, ok, we_s;
    logic [3:0]  be_s;
    logic [31:0] a_s, wd_s;

    always @(negedge clk) begin
        any = 1'b0; w1 = 1'b0; we_s = 1'b0; be_s = '0; a_s = '0; wd_s = '0;
        if (!rst) begin
            any = m0_if.req | m1_if.req;
            w1  = (m0_if.req & m1_if.req) ? m_prio1 : m1_if.req;
        end
        if (any) begin
            we_s = w1 ? m1_if.we    : m0_if.we;
            be_s = w1 ? m1_if.be    : m0_if.be;
            a_s  = w1 ? m1_if.addr  : m0_if.addr;
            wd_s = w1 ? m1_if.wdata : m0_if.wdata;
        end
        ok = any && (a_s < 256) && (be_s != 0);

        check("gnt0",     32'(m0_if.gnt), 32'(any && !w1));
        check("gnt1",     32'(m1_if.gnt), 32'(any && w1));
        check("ram_req",  32'(ram_if.req), 32'(ok));
        check("ram_we",   32'(ram_if.we), 32'(we_s));
        check("ram_be",   32'(ram_if.be), 32'(be_s));
        check("ram_addr", ram_if.addr, a_s);
        check("ram_wdata", ram_if.wdata, wd_s);
        check("rvalid0",  32'(m0_if.rvalid), 32'(pend_v && !rst && !pend_own1));
        check("rvalid1",  32'(m1_if.rvalid), 32'(pend_v && !rst && pend_own1));
        check("err0",     32'(m0_if.err), 32'(pend_v && !rst && !pend_own1 && pend_err));
        check("err1",     32'(m1_if.err), 32'(pend_v && !rst && pend_own1 && pend_err));
        check("rdata0",   m0_if.rdata, (pend_v && !rst && !pend_own1) ? pend_rd : 32'h0);
        check("rdata1",   m1_if.rdata, (pend_v && !rst && pend_own1) ? pend_rd : 32'h0);

        if (rst) begin
            m_prio1 = 1'b0;
            pend_v  = 1'b0;
        end else begin
            pend_v = any;
            if (any) begin
                m_prio1   = !w1;
                pend_own1 = w1;
                pend_err  = !ok;
                pend_rd   = (!ok || we_s) ? 32'h0 : gold[a_s[7:2]];
                if (ok && we_s)
                    for (int b = 0; b < 4; b++)
                        if (be_s[b]) gold[a_s[7:2]][8*b +: 8] = wd_s[8*b +: 8];
            end
        end
    end

    task automatic drv0(input logic r, input logic we, input logic [3:0] be,
                        input logic [31:0] a, input logic [31:0] d);
        m0_if.req = r; m0_if.we = we; m0_if.be = be; m0_if.addr = a; m0_if.wdata = d;
    endtask

    task automatic drv1(input logic r, input logic we, input logic [3:0] be,
                        input logic [31:0] a, input logic [31:0] d);
        m1_if.req = r; m1_if.we = we; m1_if.be = be; m1_if.addr = a; m1_if.wdata = d;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        drv0(0, 0, 4'h0, 32'h0, 32'h0);
        drv1(0, 0, 4'h0, 32'h0, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // idle after reset
        smp();
        check("idle_ram_req", 32'(ram_if.req), 32'h0);
        check("idle_gnts", 32'({m0_if.gnt, m1_if.gnt}), 32'h0);
        check("idle_rvalids", 32'({m0_if.rvalid, m1_if.rvalid}), 32'h0);
        cyc();

        drv1(1, 0, 4'hF, 32'h20, 32'h0);
        smp();
        check("m1_first_gnt", 32'(m1_if.gnt), 32'h1);
        cyc();

        // write then read back-to-back from m0
        drv1(0, 0, 4'h0, 32'h0, 32'h0);
        drv0(1, 1, 4'hF, 32'h10, 32'hDEAD_BEEF);
        smp();
        check("wr_gnt", 32'(m0_if.gnt), 32'h1);
        cyc();
        drv0(1, 0, 4'hF, 32'h10, 32'h0);
        smp();
        check("rd_gnt", 32'(m0_if.gnt), 32'h1);
        check("wr_ack_rvalid", 32'(m0_if.rvalid), 32'h1);
        check("wr_ack_rdata", m0_if.rdata, 32'h0);
        cyc();
        drv0(0, 0, 4'h0, 32'h0, 32'h0);
        smp();
        check("rd_rvalid", 32'(m0_if.rvalid), 32'h1);
        check("rd_rdata", m0_if.rdata, 32'hDEAD_BEEF);
        cyc();

        // m1 preloads 0x20 and partially overwrites 0x10
        drv1(1, 1, 4'hF, 32'h20, 32'h1234_5678);
        cyc();
        drv1(1, 1, 4'h5, 32'h10, 32'hAABB_CCDD);
        cyc();
        drv1(0, 0, 4'h0, 32'h0, 32'h0);
        drv0(1, 0, 4'hF, 32'h10, 32'h0);
        cyc();
        drv0(0, 0, 4'h0, 32'h0, 32'h0);
        smp();
        check("partial_be_rdata", m0_if.rdata, 32'hDEBB_BEDD);
        cyc();

        // contention from reset: strict alternation starting with m0
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drv0(1, 0, 4'hF, 32'h10, 32'h0);
            drv1(1, 0, 4'hF, 32'h20, 32'h0);
            smp();
            check("rr_gnt0", 32'(m0_if.gnt), 32'((i % 2) == 0));
            check("rr_gnt1", 32'(m1_if.gnt), 32'((i % 2) == 1));
            if (i > 0) begin
                check("rr_rvalid0", 32'(m0_if.rvalid), 32'((i % 2) == 1));
                check("rr_rvalid1", 32'(m1_if.rvalid), 32'((i % 2) == 0));
            end
            cyc();
        end
        drv0(0, 0, 4'h0, 32'h0, 32'h0);
        drv1(0, 0, 4'h0, 32'h0, 32'h0);
        smp();
        check("rr_last_rvalid1", 32'(m1_if.rvalid), 32'h1);
        check("rr_last_rdata1", m1_if.rdata, 32'h1234_5678);
        cyc();

        // out-of-range accesses
        drv1(1, 0, 4'hF, 32'h100, 32'h0);
        smp();
        check("oor_gnt", 32'(m1_if.gnt), 32'h1);
        check("oor_ram_req", 32'(ram_if.req), 32'h0);
        cyc();
        drv1(1, 0, 4'hF, 32'hFFFF_FFFC, 32'h0);
        smp();
        check("oor_rvalid", 32'(m1_if.rvalid), 32'h1);
        check("oor_err", 32'(m1_if.err), 32'h1);
        check("oor_rdata", m1_if.rdata, 32'h0);
        cyc();
        drv1(0, 0, 4'h0, 32'h0, 32'h0);
        smp();
        check("oor_high_err", 32'(m1_if.err), 32'h1);
        cyc();

        // zero byte-enable write must not touch RAM
        drv0(1, 1, 4'h0, 32'h20, 32'hFFFF_FFFF);
        smp();
        check("be0_gnt", 32'(m0_if.gnt), 32'h1);
        check("be0_ram_req", 32'(ram_if.req), 32'h0);
        cyc();
        drv0(1, 0, 4'hF, 32'h20, 32'h0);
        smp();
        check("be0_err", 32'(m0_if.err), 32'h1);
        cyc();
        drv0(0, 0, 4'h0, 32'h0, 32'h0);
        smp();
        check("be0_no_write", m0_if.rdata, 32'h1234_5678);
        cyc();

        // reset lands in the cycle a read response is due
        drv0(1, 0, 4'hF, 32'h20, 32'h0);
        smp();
        check("rst_rd_gnt", 32'(m0_if.gnt), 32'h1);
        cyc();
        drv0(0, 0, 4'h0, 32'h0, 32'h0);
        rst = 1'b1;
        smp();
        check("rst_drop_rvalid", 32'(m0_if.rvalid), 32'h0);
        check("rst_ram_req", 32'(ram_if.req), 32'h0);
        cyc();
        rst = 1'b0;
        drv0(1, 0, 4'hF, 32'h10, 32'h0);
        drv1(1, 0, 4'hF, 32'h20, 32'h0);
        smp();
        check("rst_prio_m0", 32'(m0_if.gnt), 32'h1);
        check("rst_prio_m1", 32'(m1_if.gnt), 32'h0);
        cyc();
        drv0(0, 0, 4'h0, 32'h0, 32'h0);
        drv1(0, 0, 4'h0, 32'h0, 32'h0);
        smp();
        check("post_rst_rdata", m0_if.rdata, 32'hDEBB_BEDD);
        cyc();
        repeat (3) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
